// File: rtl/jackpot_pkg.sv
// jackpot_pkg: state encoding, LED patterns and helpers shared by the jackpot round controller
package jackpot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SPIN = 3'd1,
        ST_HIT  = 3'd2,
        ST_MISS = 3'd3,
        ST_OVER = 3'd4
    } state_e;

    localparam logic [3:0] LED_OFF   = 4'b0000;
    localparam logic [3:0] LED_ALL   = 4'b1111;
    localparam logic [3:0] LED_FIRST = 4'b0001;
    localparam logic [3:0] LED_LAST  = 4'b1000;
    localparam logic [3:0] OVER_A    = 4'b1010;
    localparam logic [3:0] OVER_B    = 4'b0101;

    localparam logic [1:0] MAX_LEVEL = 2'd3;

    // One position further along the ring; LED_LAST wraps back to LED_FIRST.
    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/jackpot_tick_gen.sv
// jackpot_tick_gen: step prescaler, period TICK_DIV >> level, held at zero while clr is high
module jackpot_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] level,
    output logic       step
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d, last;

    assign last  = CW'((TICK_DIV >> level) - 1);
    assign step  = (cnt_q == last);
    assign cnt_d = (clr || step) ? '0 : cnt_q + CW'(1);

    // Free-running divider; restarts from zero on every controller state change.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/jackpot_round_ctrl.sv
// jackpot_round_ctrl: rotating-LED jackpot game sequencer (optional macro JACKPOT_SPEEDUP_EN: hits raise the step rate)
module jackpot_round_ctrl
    import jackpot_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int SHOW_STEPS = 4,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         switch,
    output logic [3:0]         led,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic               step
);

    localparam int SHOW_W = (SHOW_STEPS > 1) ? $clog2(SHOW_STEPS) : 1;

    state_e             state_q, state_d;
    logic [3:0]         led_q, led_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [SHOW_W-1:0]  show_q, show_d;
    logic               game_over_q, step_q, start_q;
    logic [3:0]         sw_meta_q, sw_s_q, sw_d_q;
    logic [3:0]         press;
    logic               tick, clr, restart, show_done;
    logic [1:0]         level;

`ifdef JACKPOT_SPEEDUP_EN
    logic [1:0] level_q, level_d;
    assign level = level_q;
`else
    assign level = 2'd0;
`endif

    assign press     = sw_s_q & ~sw_d_q;
    assign restart   = start && (state_q == ST_IDLE || (state_q == ST_OVER && !start_q));
    assign show_done = (show_q == SHOW_W'(SHOW_STEPS - 1));
    assign clr       = (state_d != state_q) || (state_q == ST_IDLE);

    jackpot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .level (level),
        .step  (tick)
    );

    // Next-state and next-output decision; a press in SPIN wins over a step in the same cycle.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        score_d = score_q;
        lives_d = lives_q;
        show_d  = show_q;
`ifdef JACKPOT_SPEEDUP_EN
        level_d = level_q;
`endif
        if (restart) begin
            state_d = ST_SPIN;
            led_d   = LED_FIRST;
            score_d = '0;
            lives_d = 2'(LIVES);
`ifdef JACKPOT_SPEEDUP_EN
            level_d = 2'd0;
`endif
        end else begin
            case (state_q)
                ST_SPIN: begin
                    if (press != 4'b0000) begin
                        show_d = '0;
                        if (press == led_q) begin
                            state_d = ST_HIT;
                            led_d   = LED_ALL;
                            score_d = (&score_q) ? score_q : score_q + SCORE_W'(1);
`ifdef JACKPOT_SPEEDUP_EN
                            level_d = (level_q == MAX_LEVEL) ? level_q : level_q + 2'd1;
`endif
                        end else begin
                            state_d = ST_MISS;
                            led_d   = LED_OFF;
                            lives_d = lives_q - 2'd1;
                        end
                    end else if (tick) begin
                        led_d = rotl(led_q);
                    end
                end
                ST_HIT, ST_MISS: begin
                    if (tick && show_done) begin
                        state_d = (state_q == ST_MISS && lives_q == 2'd0) ? ST_OVER : ST_SPIN;
                        led_d   = (state_q == ST_MISS && lives_q == 2'd0) ? OVER_A : LED_FIRST;
                    end else if (tick) begin
                        show_d = show_q + SHOW_W'(1);
                    end
                end
                ST_OVER: led_d = tick ? ((led_q == OVER_A) ? OVER_B : OVER_A) : led_q;
                default: led_d = LED_OFF;
            endcase
        end
    end

    // Registered FSM state, game outputs, start history and switch synchronizer/edge flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            led_q       <= LED_OFF;
            score_q     <= '0;
            lives_q     <= 2'(LIVES);
            show_q      <= '0;
            game_over_q <= 1'b0;
            step_q      <= 1'b0;
            start_q     <= 1'b0;
            sw_meta_q   <= 4'b0000;
            sw_s_q      <= 4'b0000;
            sw_d_q      <= 4'b0000;
`ifdef JACKPOT_SPEEDUP_EN
            level_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            show_q      <= show_d;
            game_over_q <= (state_d == ST_OVER);
            step_q      <= tick;
            start_q     <= start;
            sw_meta_q   <= switch;
            sw_s_q      <= sw_meta_q;
            sw_d_q      <= sw_s_q;
`ifdef JACKPOT_SPEEDUP_EN
            level_q     <= level_d;
`endif
        end
    end

    assign led       = led_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign step      = step_q;

endmodule

// File: tb/tb_jackpot_round_ctrl.sv
// tb_jackpot_round_ctrl: scoreboard bench for the jackpot round controller
module tb_jackpot_round_ctrl;

    localparam int TD = 8;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] switch = 4'b0000;
    logic [3:0] led;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over, step;

    jackpot_round_ctrl #(.TICK_DIV(TD), .SHOW_STEPS(SS), .LIVES(3), .SCORE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .switch    (switch),
        .led       (led),
        .score     (score),
        .lives     (lives),
        .game_over (game_over),
        .step      (step)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       all;
        logic       off;
        logic [7:0] score;
        logic [1:0] lives;
        logic       go;
    } snap_t;

    snap_t exp_q[$];
    snap_t prev;
    bit    mon_en = 1'b0;
    int    tests = 0;
    int    fails = 0;
    int    lvl = 0;
    int    exp_score = 0;
    int    exp_lives = 3;

    function automatic int per();
        return TD >> lvl;
    endfunction

    function automatic logic [3:0] rot(input logic [3:0] v, input int n);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    function automatic snap_t snap_now();
        snap_t s;
        s.all   = (led === 4'b1111);
        s.off   = (led === 4'b0000);
        s.score = score;
        s.lives = lives;
        s.go    = game_over;
        return s;
    endfunction

    task automatic push(input logic go, input logic all, input logic off);
        snap_t s;
        s.all   = all;
        s.off   = off;
        s.score = exp_score[7:0];
        s.lives = exp_lives[1:0];
        s.go    = go;
        exp_q.push_back(s);
    endtask

    // Advance one clock, sample 1 time unit after the edge, and match game events against the scoreboard.
    task automatic cyc();
        snap_t s, e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            s = snap_now();
            if (s !== prev) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_event got=%h expected=none", s);
                end else begin
                    e = exp_q.pop_front();
                    if (s !== e) begin
                        fails++;
                        $display("FAIL sb_event got=%h expected=%h", s, e);
                    end
                end
                prev = s;
            end
        end
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (step !== 1'b1 && n < 200);
    endtask

    task automatic wait_step_led(input logic [3:0] target);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(step === 1'b1 && led === target) && n < 400);
        tests++;
        if (!(step === 1'b1 && led === target)) begin
            fails++;
            $display("FAIL wait_led got=%b expected=%b", led, target);
        end
    endtask

    // Drive a switch pattern dly cycles after led reaches target, then check judgement latency, display length and exit.
    task automatic do_press(input logic [3:0] target, input int dly, input logic [3:0] sw, input bit hit, input bit chk_step);
        int k, d;
        logic [3:0] disp;
        logic       over;
        wait_step_led(target);
        repeat (dly) cyc();
        switch = sw;
        if (hit) begin
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
`ifdef JACKPOT_SPEEDUP_EN
            lvl = (lvl == 3) ? 3 : lvl + 1;
`endif
        end else begin
            exp_lives--;
        end
        over = !hit && exp_lives == 0;
        disp = hit ? 4'b1111 : 4'b0000;
        push(1'b0, hit, !hit);
        push(over, 1'b0, 1'b0);
        k = 0;
        do begin
            cyc();
            k++;
        end while (led !== disp && k < 20);
        tests++;
        if (k != 3) begin
            fails++;
            $display("FAIL press_latency got=%0d expected=3", k);
        end
        if (chk_step) begin
            tests++;
            if (step !== 1'b1) begin
                fails++;
                $display("FAIL press_with_step step=%b expected=1", step);
            end
        end
        switch = 4'b0000;
        d = 0;
        do begin
            cyc();
            d++;
        end while (led === disp && d < 100);
        tests++;
        if (d != SS * per()) begin
            fails++;
            $display("FAIL display_len got=%0d expected=%0d", d, SS * per());
        end
        tests++;
        if (led !== (over ? 4'b1010 : 4'b0001) || game_over !== over) begin
            fails++;
            $display("FAIL display_exit led=%b go=%b expected led=%b go=%b", led, game_over, over ? 4'b1010 : 4'b0001, over);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        tests++;
        if (led !== 4'b0000) begin fails++; $display("FAIL reset_led got=%b expected=0000", led); end
        tests++;
        if (score !== 8'd0) begin fails++; $display("FAIL reset_score got=%0d expected=0", score); end
        tests++;
        if (lives !== 2'd3) begin fails++; $display("FAIL reset_lives got=%0d expected=3", lives); end
        tests++;
        if (game_over !== 1'b0 || step !== 1'b0) begin fails++; $display("FAIL reset_flags go=%b step=%b expected 0 0", game_over, step); end
        rst = 1'b0;
        repeat (20) cyc();
        tests++;
        if (led !== 4'b0000 || step !== 1'b0) begin fails++; $display("FAIL idle_hold led=%b step=%b expected 0000 0", led, step); end
        prev   = snap_now();
        mon_en = 1'b1;
    endtask

    task automatic test_spin();
        logic [3:0] seq [4];
        int n;
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_score = 0;
        exp_lives = 3;
        lvl = 0;
        push(1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        tests++;
        if (led !== 4'b0001) begin fails++; $display("FAIL start_led got=%b expected=0001", led); end
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            tests++;
            if (n != 8 || led !== seq[i]) begin
                fails++;
                $display("FAIL spin_step%0d spacing=%0d led=%b expected spacing=8 led=%b", i, n, led, seq[i]);
            end
        end
    endtask

    task automatic test_hit();
        int n;
        do_press(4'b0100, 0, rot(4'b0100, 2 / per()), 1'b1, 1'b0);
        wait_step(n);
        tests++;
        if (n != per() || n != (TD >> lvl)) begin fails++; $display("FAIL post_hit_spacing got=%0d expected=%0d", n, per()); end
    endtask

    task automatic test_miss();
        do_press(4'b1000, 0, 4'b0001, 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle();
        do_press(4'b0010, per() - 3, 4'b0010, 1'b1, 1'b1);
        if (per() >= 3) do_press(4'b0010, per() - 3, 4'b0011, 1'b0, 1'b1);
        else            do_press(4'b0010, 0, 4'b0011, 1'b0, 1'b0);
    endtask

    task automatic test_over();
        int n;
        do_press(4'b0001, 0, 4'b1000, 1'b0, 1'b0);
        wait_step(n);
        tests++;
        if (n != per() || led !== 4'b0101) begin fails++; $display("FAIL over_toggle1 spacing=%0d led=%b expected %0d 0101", n, led, per()); end
        wait_step(n);
        tests++;
        if (n != per() || led !== 4'b1010) begin fails++; $display("FAIL over_toggle2 spacing=%0d led=%b expected %0d 1010", n, led, per()); end
        switch = 4'b1111;
        repeat (20) cyc();
        switch = 4'b0000;
        repeat (4) cyc();
        tests++;
        if (game_over !== 1'b1 || score !== 8'd2 || lives !== 2'd0) begin
            fails++;
            $display("FAIL over_hold go=%b score=%0d lives=%0d expected 1 2 0", game_over, score, lives);
        end
    endtask

    task automatic test_restart();
        int n;
        exp_score = 0;
        exp_lives = 3;
        lvl = 0;
        push(1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        tests++;
        if (led !== 4'b0001 || score !== 8'd0 || lives !== 2'd3 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL restart led=%b score=%0d lives=%0d go=%b expected 0001 0 3 0", led, score, lives, game_over);
        end
        wait_step(n);
        tests++;
        if (n != 8 || led !== 4'b0010) begin fails++; $display("FAIL restart_spacing got=%0d led=%b expected 8 0010", n, led); end
        start = 1'b0;
    endtask

    task automatic test_rst_mid_hit();
        int k;
        exp_score = 1;
        push(1'b0, 1'b1, 1'b0);
        wait_step_led(4'b0001);
        switch = 4'b0001;
        k = 0;
        do begin
            cyc();
            k++;
        end while (led !== 4'b1111 && k < 20);
        tests++;
        if (k != 3) begin fails++; $display("FAIL hit_before_rst latency=%0d expected=3", k); end
        repeat (3) cyc();
        rst    = 1'b1;
        mon_en = 1'b0;
        cyc();
        tests++;
        if (led !== 4'b0000 || score !== 8'd0 || lives !== 2'd3 || game_over !== 1'b0 || step !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_hit led=%b score=%0d lives=%0d go=%b step=%b expected 0000 0 3 0 0", led, score, lives, game_over, step);
        end
        rst    = 1'b0;
        switch = 4'b0000;
        exp_q.delete();
        repeat (12) cyc();
        tests++;
        if (led !== 4'b0000 || step !== 1'b0) begin fails++; $display("FAIL idle_after_rst led=%b step=%b expected 0000 0", led, step); end
        prev   = snap_now();
        mon_en = 1'b1;
    endtask

`ifdef JACKPOT_SPEEDUP_EN
    task automatic test_speedup();
        int want [4];
        int n;
        want = '{4, 2, 1, 1};
        exp_score = 0;
        exp_lives = 3;
        lvl = 0;
        push(1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_press(4'b0001, 0, rot(4'b0001, 2 / per()), 1'b1, 1'b0);
            wait_step(n);
            tests++;
            if (n != want[i]) begin fails++; $display("FAIL speedup_hit%0d spacing=%0d expected=%0d", i, n, want[i]); end
        end
    endtask
`endif

    task automatic test_drain();
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL sb_drain pending=%0d expected=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_spin();
        test_hit();
        test_miss();
        test_same_cycle();
        test_over();
        test_restart();
        test_rst_mid_hit();
`ifdef JACKPOT_SPEEDUP_EN
        test_speedup();
`endif
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
